uart_rx_fifo: RTL and testbench

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

---
 rtl/uart_pkg.sv | 7 +
 rtl/uart_rx_fifo_if.sv | 35 +++
 rtl/uart_fifo_mem.sv | 26 ++
 rtl/uart_rx_fifo.sv | 96 +++++++++
 tb/tb_uart_rx_fifo.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Constants shared by the UART receiver, its RX FIFO and the MMIO decoder.
package uart_pkg;

    localparam int UART_DATA_W                = 8;
    localparam int UART_RX_FIFO_DEPTH_DEFAULT = 8;

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Receive-side data path between the UART receiver, the RX FIFO and the CPU load path.
interface uart_rx_fifo_if
    import uart_pkg::*;
#(
    parameter int WIDTH = UART_DATA_W
);

    // Handshake: a transfer happens on a rising clk edge where valid && ready are both 1.
    // valid never waits on ready, and data is held stable while valid && !ready.
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready,
        input  out_data,
        input  out_valid,
        output out_ready
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready,
        output out_data,
        output out_valid,
        input  out_ready
    );

endinterface

// File: rtl/uart_fifo_mem.sv
// DEPTH x WIDTH register array: one synchronous write port, one asynchronous read port.
module uart_fifo_mem #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    // Contents are deliberately left unreset; occupancy decides what is valid.
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive FIFO, first-word fall-through, pointer + occupancy counter.
// Define UART_RX_FIFO_STATUS_EN to add the count / full_seen / clr_status status ports.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = UART_RX_FIFO_DEPTH_DEFAULT,
    parameter int WIDTH = UART_DATA_W
) (
    input  logic                   clk,
    input  logic                   rst_n,
    uart_rx_fifo_if.slave          bus
`ifdef UART_RX_FIFO_STATUS_EN
    ,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full_seen,
    input  logic                   clr_status
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] occ;
    logic          armed;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;

    // in_ready depends only on flops, so a stalled CPU never reaches back to the receiver.
    // armed keeps in_ready low in reset and raises it on the first edge after release.
    assign full          = (occ == CW'(DEPTH));
    assign empty         = (occ == '0);
    assign bus.in_ready  = armed && !full;
    assign bus.out_valid = !empty;

    assign push = bus.in_valid && bus.in_ready;
    assign pop  = bus.out_valid && bus.out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
            armed  <= 1'b0;
        end else begin
            armed <= 1'b1;
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            unique case ({push, pop})
                2'b10:   occ <= occ + CW'(1);
                2'b01:   occ <= occ - CW'(1);
                default: occ <= occ;
            endcase
        end
    end

    // Head entry is read straight from the array: no in_data to out_data bypass.
    uart_fifo_mem #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr),
        .wdata (bus.in_data),
        .raddr (rd_ptr),
        .rdata (bus.out_data)
    );

`ifdef UART_RX_FIFO_STATUS_EN
    logic fill_edge;

    // Only a push without a pop can take occupancy from DEPTH-1 to DEPTH.
    assign fill_edge = push && !pop && (occ == CW'(DEPTH - 1));
    assign count     = occ;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_seen <= 1'b0;
        end else if (fill_edge) begin
            full_seen <= 1'b1;
        end else if (clr_status) begin
            full_seen <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: reference queue model, immediate assertions per check.
module tb_uart_rx_fifo;
  import uart_pkg::*;

  localparam int DEPTH = 8;
  localparam int WIDTH = 8;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic clk;
  logic rst_n;
  logic clr_status;
  logic [CW-1:0] count;
  logic full_seen;

  uart_rx_fifo_if #(.WIDTH(WIDTH)) bus ();

  uart_rx_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus.slave)
`ifdef UART_RX_FIFO_STATUS_EN
    ,
    .count      (count),
    .full_seen  (full_seen),
    .clr_status (clr_status)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifndef UART_RX_FIFO_STATUS_EN
  assign count     = '0;
  assign full_seen = 1'b0;
`endif

  // scoreboard and reference model
  int checks   = 0;
  int failures = 0;
  logic [WIDTH-1:0] exp_q[$];
  int mcount;
  bit m_rdy;
  bit m_full_seen;
  int pops;
  logic [WIDTH-1:0] last_pop;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit v, input logic [WIDTH-1:0] d, input bit r, input bit c);
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.out_ready = r;
    clr_status    = c;
  endtask

  task automatic model_reset();
    exp_q.delete();
    mcount      = 0;
    m_rdy       = 1'b0;
    m_full_seen = 1'b0;
  endtask

  // Check outputs against the model, take one clock edge, then advance the model.
  task automatic cycle(output bit pushed);
    bit push_m;
    bit pop_m;
    logic [WIDTH-1:0] din;
    chk("in_ready", 32'(bus.in_ready), 32'(m_rdy && (mcount < DEPTH)));
    chk("out_valid", 32'(bus.out_valid), 32'(mcount > 0));
    if (mcount > 0) chk("out_data", 32'(bus.out_data), 32'(exp_q[0]));
`ifdef UART_RX_FIFO_STATUS_EN
    chk("count", 32'(count), 32'(mcount));
    chk("full_seen", 32'(full_seen), 32'(m_full_seen));
`endif
    push_m = bus.in_valid && m_rdy && (mcount < DEPTH);
    pop_m  = bus.out_ready && (mcount > 0);
    din    = bus.in_data;
    @(posedge clk);
    #1;
    if (pop_m) begin
      last_pop = exp_q.pop_front();
      pops++;
    end
    if (push_m) exp_q.push_back(din);
    if (push_m && !pop_m && (mcount == DEPTH - 1)) m_full_seen = 1'b1;
    else if (clr_status) m_full_seen = 1'b0;
    mcount = mcount + int'(push_m) - int'(pop_m);
    m_rdy  = 1'b1;
    pushed = push_m;
  endtask

  initial begin
    bit p;
    logic [WIDTH-1:0] nxt;

    // reset state
    rst_n = 1'b0;
    drive(1'b0, '0, 1'b0, 1'b0);
    model_reset();
    pops = 0;
    last_pop = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
`ifdef UART_RX_FIFO_STATUS_EN
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_full_seen", 32'(full_seen), 32'd0);
`endif
    #2 rst_n = 1'b1;
    cycle(p);
    chk("ready_after_release", 32'(bus.in_ready), 32'd1);

    // single byte 0x41
    drive(1'b1, 8'h41, 1'b0, 1'b0);
    cycle(p);
    drive(1'b0, '0, 1'b0, 1'b0);
    chk("first_valid", 32'(bus.out_valid), 32'd1);
    chk("first_data", 32'(bus.out_data), 32'h41);
`ifdef UART_RX_FIFO_STATUS_EN
    chk("first_count", 32'(count), 32'd1);
`endif
    drive(1'b0, '0, 1'b1, 1'b0);
    cycle(p);
    chk("first_pop", 32'(last_pop), 32'h41);
    drive(1'b0, '0, 1'b0, 1'b0);
    cycle(p);

    // fill with 0x00..0x07, then offer a rejected 9th byte
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, WIDTH'(i), 1'b0, 1'b0);
      cycle(p);
    end
    chk("full_in_ready", 32'(bus.in_ready), 32'd0);
`ifdef UART_RX_FIFO_STATUS_EN
    chk("full_seen_set", 32'(full_seen), 32'd1);
`endif
    drive(1'b1, 8'hAA, 1'b0, 1'b0);
    cycle(p);
    cycle(p);
    chk("ninth_rejected_ready", 32'(bus.in_ready), 32'd0);
    chk("ninth_rejected_head", 32'(bus.out_data), 32'h00);

    // streaming from full: 20 pops must be 0x00..0x13
    pops = 0;
    nxt  = 8'h08;
    drive(1'b1, nxt, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) begin
      cycle(p);
      if (p) nxt = nxt + 8'd1;
      bus.in_data = nxt;
    end
    chk("stream_pop_count", 32'(pops), 32'd20);
    chk("stream_last_pop", 32'(last_pop), 32'h13);

    // drain to occupancy 3, then 10 cycles of push+pop across the pointer wrap
    drive(1'b0, '0, 1'b1, 1'b0);
    repeat (4) cycle(p);
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, WIDTH'(8'h30 + i), 1'b1, 1'b0);
      cycle(p);
    end
    drive(1'b0, '0, 1'b0, 1'b0);
`ifdef UART_RX_FIFO_STATUS_EN
    chk("steady_count", 32'(count), 32'd3);
`endif
    chk("steady_head", 32'(bus.out_data), 32'h37);

    // full_seen clear below full, then clear on the filling edge
    drive(1'b0, '0, 1'b0, 1'b1);
    cycle(p);
    drive(1'b0, '0, 1'b0, 1'b0);
`ifdef UART_RX_FIFO_STATUS_EN
    chk("full_seen_cleared", 32'(full_seen), 32'd0);
`endif
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, WIDTH'(8'h50 + i), 1'b0, i == 4);
      cycle(p);
    end
    drive(1'b0, '0, 1'b0, 1'b0);
`ifdef UART_RX_FIFO_STATUS_EN
    chk("full_seen_set_wins", 32'(full_seen), 32'd1);
`endif
    cycle(p);

    // occupancy 5, asynchronous reset between edges
    drive(1'b0, '0, 1'b1, 1'b0);
    repeat (3) cycle(p);
    drive(1'b0, '0, 1'b0, 1'b0);
    chk("pre_reset_valid", 32'(bus.out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("async_out_valid", 32'(bus.out_valid), 32'd0);
    chk("async_in_ready", 32'(bus.in_ready), 32'd0);
`ifdef UART_RX_FIFO_STATUS_EN
    chk("async_count", 32'(count), 32'd0);
    chk("async_full_seen", 32'(full_seen), 32'd0);
`endif
    @(posedge clk);
    #3 rst_n = 1'b1;
    cycle(p);
    chk("ready_after_rerelease", 32'(bus.in_ready), 32'd1);
    drive(1'b1, 8'h77, 1'b0, 1'b0);
    cycle(p);
    drive(1'b0, '0, 1'b1, 1'b0);
    cycle(p);
    chk("post_reset_pop", 32'(last_pop), 32'h77);
    drive(1'b0, '0, 1'b0, 1'b0);
    cycle(p);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
